// File: rtl/vlc_tx_frame_if.sv
// Handshake and drive-line bundle between the framing stage and the VLC transmitter.
// The master supplies payload and mode; the slave (transmitter) returns ready, LED bit and status.
interface vlc_tx_frame_if #(
   parameter int DATA_W = 36
);
   logic              mode_manchester;
   logic              data_valid;
   logic [DATA_W-1:0] data_in;
   logic              data_ready;
   logic              out;
   logic              tx_busy;
   logic              tx_complete;

   modport master (
      output mode_manchester,
      output data_valid,
      output data_in,
      input  data_ready,
      input  out,
      input  tx_busy,
      input  tx_complete
   );

   modport slave (
      input  mode_manchester,
      input  data_valid,
      input  data_in,
      output data_ready,
      output out,
      output tx_busy,
      output tx_complete
   );
endinterface

// File: rtl/vlc_tx_frame.sv
// VLC frame transmitter: sync + payload serialised MSB-first, OOK or Manchester; first bit 1 cycle after accept.
// Accepts only in IDLE (data_ready high); no buffering, valid while busy is dropped.
module vlc_tx_frame #(
   parameter int                DATA_W       = 36,
   parameter int                SYNC_W       = 8,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'b10101010,
   parameter int                CLKS_PER_BIT = 1,
   parameter int                GAP_BITS     = 0,
   parameter logic              IDLE_LEVEL   = 1'b0
) (
   input logic           clk,
   input logic           rst_n,
   vlc_tx_frame_if.slave bus
);
   localparam int FRAME_W = SYNC_W + DATA_W;
   localparam int BCW     = $clog2(FRAME_W + 1);
   localparam int CCW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int GAP_OOK = GAP_BITS * CLKS_PER_BIT;
   localparam int GAP_MAN = 2 * GAP_OOK;
   localparam int GCW     = (GAP_MAN > 0) ? $clog2(GAP_MAN + 1) : 1;

   localparam logic [BCW-1:0] BIT_LAST    = BCW'(FRAME_W - 1);
   localparam logic [CCW-1:0] CYC_LAST    = CCW'(CLKS_PER_BIT - 1);
   localparam logic [GCW-1:0] GAP_LEN_OOK = GCW'(GAP_OOK);
   localparam logic [GCW-1:0] GAP_LEN_MAN = GCW'(GAP_MAN);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   state_t             state;
   logic [FRAME_W-1:0] shreg;
   logic [BCW-1:0]     bit_cnt;
   logic [CCW-1:0]     cyc_cnt;
   logic [GCW-1:0]     gap_cnt;
   logic               half;
   logic               man;
   logic               out_q;
   logic               ready_q;
   logic               busy_q;
   logic               cmp_q;

   logic               period_end;
   logic               last_bit;
   logic [GCW-1:0]     gap_len;

   assign period_end = (cyc_cnt == CYC_LAST);
   assign last_bit   = (bit_cnt == BIT_LAST);
   assign gap_len    = man ? GAP_LEN_MAN : GAP_LEN_OOK;

   assign bus.data_ready  = ready_q;
   assign bus.out         = out_q;
   assign bus.tx_busy     = busy_q;
   assign bus.tx_complete = cmp_q;

   // Manchester first half is the inverted bit, second half the bit itself, so bit ^ man
   // gives the first-half level in both modes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         cyc_cnt <= '0;
         gap_cnt <= '0;
         half    <= 1'b0;
         man     <= 1'b0;
         out_q   <= IDLE_LEVEL;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         cmp_q   <= 1'b0;
      end else begin
         cmp_q <= 1'b0;
         case (state)
            IDLE: begin
               if (ready_q && bus.data_valid) begin
                  state   <= SEND;
                  shreg   <= {SYNC_PATTERN, bus.data_in};
                  man     <= bus.mode_manchester;
                  bit_cnt <= '0;
                  cyc_cnt <= '0;
                  gap_cnt <= '0;
                  half    <= 1'b0;
                  out_q   <= SYNC_PATTERN[SYNC_W-1] ^ bus.mode_manchester;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end else begin
                  out_q   <= IDLE_LEVEL;
                  ready_q <= 1'b1;
               end
            end

            SEND: begin
               if (!period_end) begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end else begin
                  cyc_cnt <= '0;
                  if (man && !half) begin
                     half  <= 1'b1;
                     out_q <= shreg[FRAME_W-1];
                  end else begin
                     half    <= 1'b0;
                     bit_cnt <= bit_cnt + 1'b1;
                     if (last_bit) begin
                        out_q   <= IDLE_LEVEL;
                        cmp_q   <= 1'b1;
                        gap_cnt <= '0;
                        if (GAP_BITS == 0) begin
                           state   <= IDLE;
                           ready_q <= 1'b1;
                           busy_q  <= 1'b0;
                        end else begin
                           state <= GAP;
                        end
                     end else begin
                        shreg <= {shreg[FRAME_W-2:0], 1'b0};
                        out_q <= shreg[FRAME_W-2] ^ man;
                     end
                  end
               end
            end

            // The tx_complete cycle is the first GAP cycle; the forced gap follows it.
            GAP: begin
               if (gap_cnt == gap_len) begin
                  state   <= IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_vlc_tx_frame.sv
// Bench for vlc_tx_frame: three instances (OOK/CPB=1, CPB=2, CPB=3 with gap) against a waveform-list model.
`timescale 1ns/1ps
module tb_vlc_tx_frame;
   localparam logic [7:0] SYNC = 8'b10101010;

   typedef struct packed {
      logic o;
      logic busy;
      logic cmp;
      logic rdy;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   exp_t sched [3][0:511];
   int   len [3];
   int   pos [3];
   exp_t cur [3];

   always #5 clk = ~clk;

   vlc_tx_frame_if #(.DATA_W(36)) ifa ();
   vlc_tx_frame_if #(.DATA_W(36)) ifb ();
   vlc_tx_frame_if #(.DATA_W(36)) ifc ();

   vlc_tx_frame #(.DATA_W(36), .SYNC_W(8), .SYNC_PATTERN(SYNC), .CLKS_PER_BIT(1),
                  .GAP_BITS(0), .IDLE_LEVEL(1'b0))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   vlc_tx_frame #(.DATA_W(36), .SYNC_W(8), .SYNC_PATTERN(SYNC), .CLKS_PER_BIT(2),
                  .GAP_BITS(0), .IDLE_LEVEL(1'b0))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   vlc_tx_frame #(.DATA_W(36), .SYNC_W(8), .SYNC_PATTERN(SYNC), .CLKS_PER_BIT(3),
                  .GAP_BITS(2), .IDLE_LEVEL(1'b0))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

   function automatic int cpb_of(int k);
      case (k)
         0: return 1;
         1: return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int gap_of(int k);
      return (k == 2) ? 2 : 0;
   endfunction

   function automatic logic g_out(int k);
      case (k)
         0: return ifa.out;
         1: return ifb.out;
         default: return ifc.out;
      endcase
   endfunction

   function automatic logic g_busy(int k);
      case (k)
         0: return ifa.tx_busy;
         1: return ifb.tx_busy;
         default: return ifc.tx_busy;
      endcase
   endfunction

   function automatic logic g_cmp(int k);
      case (k)
         0: return ifa.tx_complete;
         1: return ifb.tx_complete;
         default: return ifc.tx_complete;
      endcase
   endfunction

   function automatic logic g_rdy(int k);
      case (k)
         0: return ifa.data_ready;
         1: return ifb.data_ready;
         default: return ifc.data_ready;
      endcase
   endfunction

   function automatic logic g_valid(int k);
      case (k)
         0: return ifa.data_valid;
         1: return ifb.data_valid;
         default: return ifc.data_valid;
      endcase
   endfunction

   function automatic logic [35:0] g_data(int k);
      case (k)
         0: return ifa.data_in;
         1: return ifb.data_in;
         default: return ifc.data_in;
      endcase
   endfunction

   function automatic logic g_mode(int k);
      case (k)
         0: return ifa.mode_manchester;
         1: return ifb.mode_manchester;
         default: return ifc.mode_manchester;
      endcase
   endfunction

   function automatic exp_t mk(logic o, logic busy, logic cmp, logic rdy);
      exp_t e;
      e.o = o; e.busy = busy; e.cmp = cmp; e.rdy = rdy;
      return e;
   endfunction

   function automatic logic [35:0] rnd36();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[35:0];
   endfunction

   task automatic set_in(int k, logic v, logic [35:0] d, logic m);
      case (k)
         0: begin ifa.data_valid = v; ifa.data_in = d; ifa.mode_manchester = m; end
         1: begin ifb.data_valid = v; ifb.data_in = d; ifb.mode_manchester = m; end
         default: begin ifc.data_valid = v; ifc.data_in = d; ifc.mode_manchester = m; end
      endcase
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: on accept, lay out the whole expected waveform (frame, completion, gap) as a list.
   task automatic model_step(int k);
      logic [43:0] frame;
      logic        m;
      int          n;
      int          cpb;
      int          gcyc;
      if (!rst_n) begin
         len[k] = 0;
         pos[k] = 0;
         cur[k] = mk(1'b0, 1'b0, 1'b0, 1'b0);
      end else if (pos[k] < len[k]) begin
         cur[k] = sched[k][pos[k]];
         pos[k]++;
      end else if (cur[k].rdy && g_valid(k)) begin
         frame = {SYNC, g_data(k)};
         m     = g_mode(k);
         cpb   = cpb_of(k);
         n     = 0;
         for (int b = 43; b >= 0; b--) begin
            if (m) begin
               for (int c = 0; c < cpb; c++) begin sched[k][n] = mk(~frame[b], 1'b1, 1'b0, 1'b0); n++; end
               for (int c = 0; c < cpb; c++) begin sched[k][n] = mk(frame[b], 1'b1, 1'b0, 1'b0); n++; end
            end else begin
               for (int c = 0; c < cpb; c++) begin sched[k][n] = mk(frame[b], 1'b1, 1'b0, 1'b0); n++; end
            end
         end
         sched[k][n] = mk(1'b0, gap_of(k) > 0, 1'b1, gap_of(k) == 0);
         n++;
         gcyc = gap_of(k) * cpb * (m ? 2 : 1);
         for (int g = 0; g < gcyc; g++) begin sched[k][n] = mk(1'b0, 1'b1, 1'b0, 1'b0); n++; end
         len[k] = n;
         cur[k] = sched[k][0];
         pos[k] = 1;
      end else begin
         cur[k] = mk(1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) model_step(k);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("out[%0d]", k),  64'(g_out(k)),  64'(cur[k].o));
            chk($sformatf("busy[%0d]", k), 64'(g_busy(k)), 64'(cur[k].busy));
            chk($sformatf("cmp[%0d]", k),  64'(g_cmp(k)),  64'(cur[k].cmp));
            chk($sformatf("rdy[%0d]", k),  64'(g_rdy(k)),  64'(cur[k].rdy));
         end
      end
   end

   // Called on a negedge while instance k is ready; returns in the first cycle after accept.
   task automatic start(int k, logic [35:0] d, logic m);
      set_in(k, 1'b1, d, m);
      @(negedge clk);
      set_in(k, 1'b0, d, m);
   endtask

   task automatic capture_a(output logic [43:0] bits, output int done_c);
      bits   = '0;
      done_c = 0;
      for (int c = 1; c <= 100; c++) begin
         if (c <= 44) bits[44-c] = ifa.out;
         if (ifa.tx_complete) begin done_c = c; break; end
         @(negedge clk);
      end
   endtask

   initial begin
      logic [43:0] bits;
      logic [35:0] d;
      logic [7:0]  first8;
      logic [3:0]  pay4;
      int          done_c;
      int          nbusy;
      int          ncmp;
      int          nrdy;
      int          bad;
      int          ngap;
      int          last_c;

      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) set_in(k, 1'b0, 36'h0, 1'b0);
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_out_a", 64'(ifa.out), 64'(0));
      chk("rst_rdy_a", 64'(ifa.data_ready), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_release", 64'(ifa.data_ready), 64'(1));
      @(negedge clk);

      // Default OOK frame with the reference word
      start(0, 36'h123456789, 1'b0);
      capture_a(bits, done_c);
      chk("t1_bits", 64'(bits), 64'({SYNC, 36'h123456789}));
      chk("t1_complete_cycle", 64'(done_c), 64'(45));
      @(negedge clk);
      chk("t1_out_after", 64'(ifa.out), 64'(0));

      // Manchester, CPB=2, all-zero payload
      start(1, 36'h0, 1'b1);
      first8 = '0; pay4 = '0; nbusy = 0; done_c = 0;
      for (int c = 1; c <= 300; c++) begin
         if (c <= 8) first8[8-c] = ifb.out;
         if (c >= 33 && c <= 36) pay4[36-c] = ifb.out;
         if (ifb.tx_complete) begin done_c = c; break; end
         if (ifb.tx_busy) nbusy++;
         @(negedge clk);
      end
      chk("t2_sync_halves", 64'(first8), 64'(8'b00111100));
      chk("t2_payload_halves", 64'(pay4), 64'(4'b1100));
      chk("t2_complete_cycle", 64'(done_c), 64'(177));
      chk("t2_busy_cycles", 64'(nbusy), 64'(176));
      set_in(1, 1'b0, 36'h0, 1'b0);

      // Valid held high for three back-to-back frames
      d = rnd36();
      set_in(0, 1'b1, d, 1'b0);
      ncmp = 0; nrdy = 0; bad = 0; last_c = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (ifa.tx_complete) ncmp++;
         if (ifa.data_ready) nrdy++;
         if (ifa.data_ready && !ifa.tx_complete) bad++;
         if (ncmp == 3) begin set_in(0, 1'b0, d, 1'b0); last_c = c; break; end
      end
      chk("t3_completes", 64'(ncmp), 64'(3));
      chk("t3_ready_cycles", 64'(nrdy), 64'(3));
      chk("t3_ready_outside_cmp", 64'(bad), 64'(0));
      chk("t3_third_cmp_cycle", 64'(last_c), 64'(135));
      @(negedge clk);
      chk("t3_idle_after", 64'(ifa.tx_busy), 64'(0));

      // Inter-frame gap, CPB=3, GAP_BITS=2
      start(2, rnd36(), 1'b0);
      done_c = 0;
      for (int c = 1; c <= 300; c++) begin
         if (ifc.tx_complete) begin done_c = c; break; end
         @(negedge clk);
      end
      chk("t4_complete_cycle", 64'(done_c), 64'(133));
      chk("t4_rdy_at_cmp", 64'(ifc.data_ready), 64'(0));
      ngap = 0; bad = 0;
      for (int g = 1; g <= 20; g++) begin
         @(negedge clk);
         if (ifc.data_ready) break;
         ngap++;
         if (ifc.out !== 1'b0) bad++;
      end
      chk("t4_gap_cycles", 64'(ngap), 64'(6));
      chk("t4_gap_level", 64'(bad), 64'(0));
      chk("t4_rdy_after_gap", 64'(ifc.data_ready), 64'(1));

      // Mid-frame data toggle, extra valid pulse and mode change are ignored
      d = rnd36();
      start(0, d, 1'b0);
      bits = '0; done_c = 0;
      for (int c = 1; c <= 100; c++) begin
         if (c <= 44) bits[44-c] = ifa.out;
         if (ifa.tx_complete) begin done_c = c; break; end
         if (c == 10) set_in(0, 1'b1, ~d, 1'b1);
         else if (c == 11) set_in(0, 1'b0, ~d, 1'b0);
         else if (c == 20) set_in(0, 1'b0, rnd36(), 1'b1);
         @(negedge clk);
      end
      chk("t6_bits", 64'(bits), 64'({SYNC, d}));
      chk("t6_complete_cycle", 64'(done_c), 64'(45));
      set_in(0, 1'b0, d, 1'b0);
      nbusy = 0;
      repeat (60) begin
         @(negedge clk);
         if (ifa.tx_busy) nbusy++;
      end
      chk("t6_no_replay", 64'(nbusy), 64'(0));

      // Reset during bit 20 aborts the frame
      start(0, rnd36(), 1'b0);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_out_abort", 64'(ifa.out), 64'(0));
      chk("t5_busy_abort", 64'(ifa.tx_busy), 64'(0));
      chk("t5_cmp_abort", 64'(ifa.tx_complete), 64'(0));
      rst_n = 1'b1;
      ncmp = 0;
      repeat (50) begin
         @(negedge clk);
         if (ifa.tx_complete) ncmp++;
      end
      chk("t5_no_complete", 64'(ncmp), 64'(0));
      d = rnd36();
      start(0, d, 1'b0);
      capture_a(bits, done_c);
      chk("t5_new_bits", 64'(bits), 64'({SYNC, d}));
      chk("t5_new_complete", 64'(done_c), 64'(45));

      // Random traffic on all instances, checked every cycle against the model
      repeat (1500) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++)
            set_in(k, $urandom_range(0, 3) == 0, rnd36(), 1'($urandom_range(0, 1)));
      end
      for (int k = 0; k < 3; k++) set_in(k, 1'b0, 36'h0, 1'b0);
      repeat (400) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
